// File: rtl/core_dbg_regs.sv
// core_dbg_regs
//   Debug register block with byte-strobed general registers, a read-only
//   status register, and an instruction transfer register (ITR) that feeds
//   a small FIFO towards the fetch unit.
//
// Ports
//   clk        single clock
//   rst        asynchronous, active-high reset
//   req        one-cycle access request, sampled on rising clk
//   wr_rd      1 = write, 0 = read
//   addr       register address
//   wdata      write data
//   wstrb      byte write enables
//   rdata      registered read data, holds between reads
//   rd_ready   one-cycle pulse, cycle after a read request
//   err        one-cycle pulse, same timing as rd_ready
//   itr_valid  ITR queue not empty
//   itr_insn   ITR queue head
//   itr_ready  fetch accepts the head
//   itr_count  ITR queue occupancy
//
// Status register layout: [CW-1:0] count, [CW] empty, [CW+1] full,
// [CW+2] sticky overflow (write 1 to clear), other bits 0.

module core_dbg_regs #(
  parameter int  ADDR_WIDTH  = 5,
  parameter int  DATA_WIDTH  = 32,
  parameter int  NUM_REGS    = 32,
  parameter int  ITR_ADDR    = 3,
  parameter int  STATUS_ADDR = 4,
  parameter int  ITR_DEPTH   = 4,
  localparam int CW          = $clog2(ITR_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    wr_rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rd_ready,
  output logic                    err,
  output logic                    itr_valid,
  output logic [DATA_WIDTH-1:0]   itr_insn,
  input  logic                    itr_ready,
  output logic [CW-1:0]           itr_count
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = $clog2(ITR_DEPTH);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
  logic [DATA_WIDTH-1:0] itr_mem [ITR_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  overflow;

  logic                  acc_rd;
  logic                  acc_wr;
  logic                  in_range;
  logic                  is_itr;
  logic                  is_status;
  logic                  strb_full;
  logic                  q_full;
  logic                  q_empty;
  logic                  pop;
  logic                  push_req;
  logic                  push;
  logic                  ovf_set;
  logic                  ovf_clr;
  logic                  reg_we;
  logic                  err_nxt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_val;

  assign q_full    = (itr_count == CW'(ITR_DEPTH));
  assign q_empty   = (itr_count == '0);
  assign itr_valid = ~q_empty;
  assign itr_insn  = itr_mem[rd_ptr];

  always_comb begin
    acc_rd    = req & ~wr_rd;
    acc_wr    = req & wr_rd;
    // NUM_REGS may equal 2**ADDR_WIDTH, so compare one bit wider
    in_range  = ({1'b0, addr} < (ADDR_WIDTH + 1)'(NUM_REGS));
    is_itr    = (addr == ADDR_WIDTH'(ITR_ADDR));
    is_status = (addr == ADDR_WIDTH'(STATUS_ADDR));
    strb_full = &wstrb;
    idx       = addr[IW-1:0];

    pop       = itr_valid & itr_ready;
    push_req  = acc_wr & in_range & is_itr & strb_full;
    // a simultaneous pop frees the slot, so a full queue still accepts
    push      = push_req & (~q_full | pop);
    ovf_set   = push_req & q_full & ~pop;
    ovf_clr   = acc_wr & in_range & is_status & wdata[CW+2];
    reg_we    = acc_wr & in_range & ~is_status;

    err_nxt   = (req & ~in_range)
              | (acc_wr & in_range & is_itr & (~strb_full | ovf_set));

    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[b*8 +: 8] = {8{wstrb[b]}};
    end

    status             = '0;
    status[CW-1:0]     = itr_count;
    status[CW]         = q_empty;
    status[CW+1]       = q_full;
    status[CW+2]       = overflow;

    if (!in_range) begin
      rd_val = '0;
    end else if (is_status) begin
      rd_val = status;
    end else begin
      rd_val = regs[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      for (int i = 0; i < ITR_DEPTH; i++) begin
        itr_mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      itr_count <= '0;
      overflow  <= 1'b0;
      rdata     <= '0;
      rd_ready  <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_ready <= acc_rd;
      err      <= err_nxt;

      if (acc_rd) begin
        rdata <= rd_val;
      end

      if (reg_we) begin
        regs[idx] <= (regs[idx] & ~wmask) | (wdata & wmask);
      end

      // when full, wr_ptr == rd_ptr; the head is overwritten only when it
      // is being popped on this same edge
      if (push) begin
        itr_mem[wr_ptr] <= wdata;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   itr_count <= itr_count + CW'(1);
        2'b01:   itr_count <= itr_count - CW'(1);
        default: itr_count <= itr_count;
      endcase

      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_dbg_regs.sv
// Testbench for core_dbg_regs (NUM_REGS=16, other parameters default).
// Every access pushes its expected response onto a scoreboard queue; a
// negedge monitor pops and compares when the response is due.

module tb_core_dbg_regs;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          wr_rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic [DW-1:0] rdata;
  logic          rd_ready;
  logic          err;
  logic          itr_valid;
  logic [DW-1:0] itr_insn;
  logic          itr_ready = 1'b0;
  logic [CW-1:0] itr_count;

  core_dbg_regs #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .ITR_ADDR(3), .STATUS_ADDR(4), .ITR_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wr_rd(wr_rd), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .rd_ready(rd_ready),
    .err(err), .itr_valid(itr_valid), .itr_insn(itr_insn),
    .itr_ready(itr_ready), .itr_count(itr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        is_rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] rdata_hold = '0;

  // reference model
  logic [31:0] mregs [32];
  logic [31:0] mfifo[$];
  logic        movf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mstatus();
    logic [31:0] s;
    int n;
    n = mfifo.size();
    s = '0;
    s[2:0] = n[2:0];
    s[3]   = (n == 0);
    s[4]   = (n == 4);
    s[5]   = movf;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mfifo.delete();
    movf = 1'b0;
    sb.delete();
    rdata_hold = '0;
  endtask

  // One cycle of stimulus: check queue outputs against the model, drive the
  // inputs, and work out what the DUT must do with them.
  task automatic step(input logic r, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic rdy);
    exp_t e;
    int   n;
    logic full, pop, pushv, clr;
    @(posedge clk); #1;
    n = mfifo.size();
    chk("itr_count", itr_count, n);
    chk("itr_valid", itr_valid, n != 0);
    if (n != 0) chk("itr_insn", itr_insn, mfifo[0]);

    req = r; wr_rd = w; addr = a; wdata = d; wstrb = s; itr_ready = rdy;

    full  = (n == 4);
    pop   = (n > 0) && rdy;
    pushv = 1'b0;
    clr   = 1'b0;
    e.due = cyc + 1; e.is_rd = r && !w; e.data = '0; e.err = 1'b0;
    if (r) begin
      if (a >= NR) begin
        e.err = 1'b1;
      end else if (!w) begin
        e.data = (a == 4) ? mstatus() : mregs[a];
      end else if (a == 4) begin
        clr = d[CW+2];
      end else begin
        for (int b = 0; b < 4; b++) if (s[b]) mregs[a][b*8 +: 8] = d[b*8 +: 8];
        if (a == 3) begin
          if (s != 4'hF) e.err = 1'b1;
          else if (full && !pop) begin e.err = 1'b1; movf = 1'b1; end
          else pushv = 1'b1;
        end
      end
      sb.push_back(e);
    end
    if (pop) void'(mfifo.pop_front());
    if (pushv) mfifo.push_back(d);
    if (clr) movf = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input logic rdy = 1'b0);
    step(1'b1, 1'b1, a, d, s, rdy);
  endtask
  task automatic rd(input logic [4:0] a);
    step(1'b1, 1'b0, a, '0, '0, 1'b0);
  endtask
  task automatic idle(input logic rdy = 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("rd_ready", rd_ready, mon_e.is_rd);
        chk("err", err, mon_e.err);
        if (mon_e.is_rd) begin
          chk("rdata", rdata, mon_e.data);
          rdata_hold = mon_e.data;
        end else begin
          chk("rdata_hold", rdata, rdata_hold);
        end
      end else begin
        chk("rd_idle", rd_ready, 0);
        chk("err_idle", err, 0);
        chk("rdata_hold", rdata, rdata_hold);
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_count", itr_count, 0);
    chk("rst_valid", itr_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    rd(7);
    wr(7, 32'hA5A5A5A5, 4'b0101);
    rd(7);                                   // 0x00A500A5
    wr(2, 32'h12345678, 4'hF);
    wr(2, 32'hFFFFFFFF, 4'b1000);
    rd(2);                                   // 0xFF345678
    wr(3, 32'hDEADBEEF, 4'b0011);            // partial ITR write: err, no push
    rd(3);
    rd(4);

    // fill the queue, then overflow it
    wr(3, 32'h11, 4'hF);
    wr(3, 32'h22, 4'hF);
    wr(3, 32'h33, 4'hF);
    wr(3, 32'h44, 4'hF);
    rd(4);                                   // count 4, full
    wr(3, 32'h55, 4'hF);                     // dropped, err, overflow
    rd(4);
    idle();

    // push into a full queue while fetch pops
    wr(3, 32'h55, 4'hF, 1'b1);
    idle(1'b0);
    repeat (4) idle(1'b1);                   // drain 22,33,44,55
    idle(1'b1);                              // ready on empty queue
    idle(1'b0);

    // push and pop together while non-full
    wr(3, 32'h77, 4'hF);
    wr(3, 32'h88, 4'hF, 1'b1);
    idle();
    rd(4);

    // clear overflow, then out-of-range accesses
    wr(4, 32'h0000_0020, 4'h0);
    rd(4);
    rd(31);
    wr(20, 32'hCAFEF00D, 4'hF);
    rd(20);
    wr(3, 32'h99, 4'hF);                     // two entries queued

    // reset between edges with a read response pending
    rd(7);
    @(posedge clk); #1;
    chk("pre_rst_rd_ready", rd_ready, 1);
    chk("pre_rst_count", itr_count, 2);
    req = 1'b0; itr_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", itr_valid, 0);
    chk("mid_rst_count", itr_count, 0);
    chk("mid_rst_rd_ready", rd_ready, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_err", err, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    idle();
    idle();
    rd(7);
    rd(4);
    repeat (3) idle();
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
